rpn_evaluator: RTL

Postfix (RPN) expression engine that acts as the master on the stack's push/pop interface. It accepts a token stream, pushes operands, and pops two operands per operator. It pushes each ALU result back, then pops the final value and reports it together with an error code. It sits between the token front-end and the 16-entry operand stack of the calculator datapath.

---
 rtl/rpn_pkg.sv | 33 +++
 rtl/rpn_alu.sv | 29 ++
 rtl/rpn_evaluator.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN evaluator: opcodes, error codes and FSM states.
package rpn_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_UNDER = 2'd1;
    localparam logic [1:0] ERR_OVER  = 2'd2;
    localparam logic [1:0] ERR_MALF  = 2'd3;

    // StFinChk is a gap cycle so the final pop never directly follows a push.
    typedef enum logic [3:0] {
        StIdle,
        StPush,
        StPopB,
        StWaitB,
        StPopA,
        StWaitA,
        StExec,
        StFinChk,
        StFinPop,
        StFinWait,
        StDone,
        StDrainTok,
        StDrainStk
    } rpn_state_e;

endpackage

// File: rtl/rpn_alu.sv
// Combinational ALU for the RPN evaluator; all arithmetic wraps modulo 2^N.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    output logic [N-1:0] result,
    output logic         illegal
);

    // Decode the opcode; unused encodings flag the expression as malformed.
    always_comb begin
        result  = '0;
        illegal = 1'b0;
        unique case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_MUL:  result = a * b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rpn_evaluator.sv
// Postfix expression engine driving an external operand stack over push/pop.
// All outputs are registered from the next-state values, so each output lines
// up with the state that owns it.
module rpn_evaluator
    import rpn_pkg::*;
#(
    parameter int unsigned N          = 16,
    parameter int unsigned STACK_SIZE = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tok_valid,
    output logic         tok_ready,
    input  logic         tok_is_op,
    input  logic [N-1:0] tok_data,
    input  logic         tok_last,
    output logic         stk_push,
    output logic         stk_pop,
    output logic [N-1:0] stk_push_data,
    input  logic [N-1:0] stk_pop_data,
    input  logic         stk_empty,
    input  logic         stk_full,
    output logic         res_valid,
    output logic [N-1:0] res_data,
    output logic [1:0]   res_err
);

    localparam int unsigned DW = $clog2(STACK_SIZE + 1);

    rpn_state_e    state_q, state_d;
    logic [DW-1:0] depth_q, depth_d;
    logic [1:0]    err_q, err_d;
    logic          phase_q, phase_d;
    logic          last_q, last_d;
    logic [2:0]    op_q, op_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d, val_q, val_d;

    logic          tok_ready_d, push_d, pop_d, res_valid_d;
    logic [N-1:0]  push_data_d, res_data_d;
    logic [1:0]    res_err_d;

    logic          err_raise;
    logic [1:0]    err_code;
    logic          accept, depth_full, stk_mismatch;
    logic [N-1:0]  alu_result;
    logic          alu_illegal;

    assign accept       = tok_valid && tok_ready;
    assign depth_full   = (depth_q == DW'(STACK_SIZE));
    assign stk_mismatch = (stk_empty != (depth_q == '0)) || (stk_full != depth_full);

    rpn_alu #(
        .N(N)
    ) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .illegal(alu_illegal)
    );

    // Next-state, depth tracking, error latch and next-cycle output values.
    always_comb begin
        state_d   = state_q;
        depth_d   = depth_q;
        err_d     = err_q;
        phase_d   = 1'b0;
        last_d    = last_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        val_d     = val_q;
        err_raise = 1'b0;
        err_code  = ERR_NONE;

        // Depth follows the requests actually presented to the stack this cycle.
        if (stk_push) depth_d = depth_d + DW'(1);
        if (stk_pop)  depth_d = depth_d - DW'(1);

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    last_d = tok_last;
                    op_d   = tok_data[2:0];
                    val_d  = tok_data;
                    if (stk_mismatch) begin
                        err_raise = 1'b1;
                        err_code  = ERR_MALF;
                    end else if (tok_is_op && (depth_q < DW'(2))) begin
                        err_raise = 1'b1;
                        err_code  = ERR_UNDER;
                    end else if (!tok_is_op && depth_full) begin
                        err_raise = 1'b1;
                        err_code  = ERR_OVER;
                    end
                    if (err_raise) state_d = tok_last ? StDrainStk : StDrainTok;
                    else           state_d = tok_is_op ? StPopB : StPush;
                end
            end
            StPush:  state_d = last_q ? StFinChk : StIdle;
            StPopB:  state_d = StWaitB;
            StWaitB: begin
                b_d     = stk_pop_data;
                state_d = StPopA;
            end
            StPopA:  state_d = StWaitA;
            StWaitA: begin
                a_d     = stk_pop_data;
                state_d = StExec;
            end
            StExec: begin
                if (alu_illegal) begin
                    err_raise = 1'b1;
                    err_code  = ERR_MALF;
                    state_d   = last_q ? StDrainStk : StDrainTok;
                end else begin
                    val_d   = alu_result;
                    state_d = StPush;
                end
            end
            StFinChk: begin
                if (depth_q != DW'(1)) begin
                    err_raise = 1'b1;
                    err_code  = ERR_MALF;
                    state_d   = StDrainStk;
                end else begin
                    state_d = StFinPop;
                end
            end
            StFinPop:   state_d = StFinWait;
            StFinWait:  state_d = StDone;
            StDrainTok: if (accept && tok_last) state_d = StDrainStk;
            StDrainStk: begin
                // Alternate pop / idle so pops never land on consecutive cycles.
                phase_d = ~phase_q;
                if (depth_d == '0) state_d = StDone;
            end
            StDone: begin
                err_d   = ERR_NONE;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Only the first error of an expression is kept.
        if (err_raise && (err_q == ERR_NONE)) err_d = err_code;

        tok_ready_d = (state_d == StIdle) || (state_d == StDrainTok);
        push_d      = (state_d == StPush);
        push_data_d = push_d ? val_d : '0;
        pop_d       = (state_d inside {StPopB, StPopA, StFinPop}) ||
                      ((state_d == StDrainStk) && !phase_d && (depth_d != '0));
        res_valid_d = (state_d == StDone);
        res_err_d   = res_valid_d ? err_q : ERR_NONE;
        res_data_d  = (res_valid_d && (state_q == StFinWait)) ? stk_pop_data : '0;
    end

    // State and registered outputs; async active-low reset clears everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            depth_q       <= '0;
            err_q         <= ERR_NONE;
            phase_q       <= 1'b0;
            last_q        <= 1'b0;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            val_q         <= '0;
            tok_ready     <= 1'b0;
            stk_push      <= 1'b0;
            stk_pop       <= 1'b0;
            stk_push_data <= '0;
            res_valid     <= 1'b0;
            res_data      <= '0;
            res_err       <= ERR_NONE;
        end else begin
            state_q       <= state_d;
            depth_q       <= depth_d;
            err_q         <= err_d;
            phase_q       <= phase_d;
            last_q        <= last_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            val_q         <= val_d;
            tok_ready     <= tok_ready_d;
            stk_push      <= push_d;
            stk_pop       <= pop_d;
            stk_push_data <= push_data_d;
            res_valid     <= res_valid_d;
            res_data      <= res_data_d;
            res_err       <= res_err_d;
        end
    end

endmodule
